// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem requests, in-order fetch buffer, redirect flush
//
// Purpose:
//   Owns the PC and issues word fetches to an instruction memory with variable
//   latency and in-order responses. Returned words are kept with their PCs in a
//   small circular buffer and handed to decode over a valid/ready handshake.
//   A redirect flushes the buffer and arranges for the still-outstanding
//   wrong-path responses to be discarded as they come back.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr word fetch request (address is word aligned)
//   imem_rsp_valid, imem_rsp_data   in-order fetch responses
//   redirect, PCTarget              single-cycle redirect pulse and its target
//   ID_valid/ready                  handshake towards decode
//   ID_Instr, ID_PC, ID_PCPlus4     head instruction, its PC and PC + 4 (0 when not valid)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] PCTarget,
  output logic        ID_valid,
  input  logic        ID_ready,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PCPlus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ent_pc_q    [DEPTH];
  logic [31:0]       ent_pc_d    [DEPTH];
  logic [31:0]       ent_instr_q [DEPTH];
  logic [31:0]       ent_instr_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     alloc_q, alloc_d;       // entries allocated, filled or not
  logic [CW-1:0]     inflight_q, inflight_d; // accepted requests without a response yet
  logic [CW-1:0]     drop_q, drop_d;         // outstanding responses that belong to a flushed path

  logic req_fire;
  logic pop;
  logic unused_pc_lsbs;

  // Misaligned target bits are deliberately ignored.
  assign unused_pc_lsbs = ^PCTarget[1:0];

  // Occupancy counts every slot a response may still need: live allocated
  // entries plus stale responses still owed by memory. Pre-pop occupancy is
  // used, so a pop never enables a request in the same cycle.
  assign imem_req_valid = rst_n && !redirect &&
                          (({1'b0, alloc_q} + {1'b0, drop_q}) < DEPTH_C);
  assign imem_addr      = pc_q;

  assign ID_valid   = filled_q[rd_ptr_q];
  assign ID_Instr   = ID_valid ? ent_instr_q[rd_ptr_q] : 32'h0;
  assign ID_PC      = ID_valid ? ent_pc_q[rd_ptr_q] : 32'h0;
  assign ID_PCPlus4 = ID_valid ? (ent_pc_q[rd_ptr_q] + 32'd4) : 32'h0;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = ID_valid && ID_ready && !redirect;

  always_comb begin
    pc_d        = pc_q;
    ent_pc_d    = ent_pc_q;
    ent_instr_d = ent_instr_q;
    filled_d    = filled_q;
    wr_ptr_d    = wr_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    alloc_d     = alloc_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;

    if (redirect) begin
      // Everything still owed by memory is now wrong-path, including any
      // response arriving in this very cycle (it is consumed here).
      pc_d       = {PCTarget[31:2], 2'b00};
      filled_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      alloc_d    = '0;
      inflight_d = inflight_q - CW'(imem_rsp_valid);
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        ent_pc_d[wr_ptr_q] = pc_q;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + 1'b1;
        pc_d               = pc_q + 32'd4;
      end

      // Stale responses always come back before any new-path response.
      if (imem_rsp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          ent_instr_d[fill_ptr_q] = imem_rsp_data;
          filled_d[fill_ptr_q]    = 1'b1;
          fill_ptr_d              = fill_ptr_q + 1'b1;
        end
      end

      if (pop) begin
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + 1'b1;
      end

      alloc_d    = alloc_q + CW'(req_fire) - CW'(pop);
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      filled_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      alloc_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= 32'h0;
        ent_instr_q[i] <= 32'h0;
      end
    end else begin
      pc_q        <= pc_d;
      filled_q    <= filled_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      alloc_q     <= alloc_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      ent_pc_q    <= ent_pc_d;
      ent_instr_q <= ent_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] PCTarget;
  logic        ID_valid;
  logic        ID_ready;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PC;
  logic [31:0] ID_PCPlus4;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .PCTarget       (PCTarget),
    .ID_valid       (ID_valid),
    .ID_ready       (ID_ready),
    .ID_Instr       (ID_Instr),
    .ID_PC          (ID_PC),
    .ID_PCPlus4     (ID_PCPlus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  ent_t        q[$];    // instructions owed to decode, oldest first
  mreq_t       mq[$];   // requests accepted by memory, oldest first
  int          drop;    // responses still to be thrown away
  logic [31:0] mpc;     // next fetch address
  int          cyc;
  bit          last_redir;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E2D};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mq.delete();
    drop       = 0;
    mpc        = RESET_PC;
    last_redir = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check_eq({tag, "_id_valid"},  32'(ID_valid),       32'h0);
    check_eq({tag, "_id_instr"},  ID_Instr,            32'h0);
    check_eq({tag, "_id_pc"},     ID_PC,               32'h0);
    check_eq({tag, "_id_pcp4"},   ID_PCPlus4,          32'h0);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic do_cycle(input int lat_min, input int lat_max, input int p_rdy,
                          input int p_idr, input int p_redir, input int tmode);
    bit          exp_req, exp_idv, hs, pd, rsp;
    int          infl, idx;
    logic [31:0] rdata;
    @(negedge clk);
    cyc++;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    ID_ready       = ($urandom_range(99) < p_idr);
    redirect       = !last_redir && ($urandom_range(99) < p_redir);
    case (tmode)
      1:       PCTarget = 32'h0000_0100;
      2:       PCTarget = 32'h0000_0203;
      3:       PCTarget = 32'hFFFF_FFF8;
      default: PCTarget = $urandom;
    endcase
    rsp   = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = rsp ? mem_word(mq[0].addr) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    exp_req = !redirect && ((q.size() + drop) < DEPTH);
    exp_idv = (q.size() > 0) && q[0].filled;
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", imem_addr, mpc);
    check_eq("id_valid", 32'(ID_valid), 32'(exp_idv));
    check_eq("id_instr", ID_Instr,   exp_idv ? q[0].instr : 32'h0);
    check_eq("id_pc",    ID_PC,      exp_idv ? q[0].pc : 32'h0);
    check_eq("id_pcp4",  ID_PCPlus4, exp_idv ? (q[0].pc + 32'd4) : 32'h0);

    hs   = exp_req && imem_req_ready;
    pd   = exp_idv && ID_ready;
    infl = mq.size();
    if (rsp) void'(mq.pop_front());
    if (redirect) begin
      q.delete();
      drop = infl - (rsp ? 1 : 0);
      mpc  = {PCTarget[31:2], 2'b00};
    end else begin
      if (pd) void'(q.pop_front());
      if (rsp) begin
        if (drop > 0) begin
          drop--;
        end else begin
          idx = -1;
          for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && !q[i].filled) idx = i;
          end
          if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL protocol: response with no outstanding request (cycle %0d)", cyc);
          end else begin
            q[idx].instr  = rdata;
            q[idx].filled = 1'b1;
          end
        end
      end
      if (hs) begin
        q.push_back('{pc: mpc, instr: 32'h0, filled: 1'b0});
        mq.push_back('{addr: mpc, due: cyc + $urandom_range(lat_max, lat_min)});
        mpc = mpc + 32'd4;
      end
    end
    last_redir = redirect;
  endtask

  task automatic run_phase(input int n, input int lat_min, input int lat_max, input int p_rdy,
                           input int p_idr, input int p_redir, input int tmode);
    for (int i = 0; i < n; i++) do_cycle(lat_min, lat_max, p_rdy, p_idr, p_redir, tmode);
  endtask

  task automatic reset_mid_stream();
    int guard;
    guard = 0;
    while (mq.size() == 0 && guard < 50) begin
      do_cycle(3, 3, 100, 100, 0, 0);
      guard++;
    end
    check_eq("inflight_before_reset", 32'(mq.size() > 0), 32'h1);
    @(negedge clk);
    #2;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    ID_ready       = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect       = 1'b0;
    PCTarget       = 32'h0;
    ID_ready       = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // streaming: always ready, 1-cycle memory, decode always ready
    run_phase(40, 1, 1, 100, 100, 0, 0);
    // decode stalls: buffer fills, requests stop, then drain in order
    run_phase(120, 1, 1, 100, 15, 0, 0);
    // 3-cycle memory with redirects to 0x100 while fetches are outstanding
    run_phase(200, 3, 3, 100, 80, 8, 1);
    // misaligned target, redirects colliding with responses and pops
    run_phase(200, 1, 2, 90, 70, 12, 2);
    // fetch across the top of the address space
    run_phase(200, 1, 3, 80, 80, 6, 3);
    reset_mid_stream();
    run_phase(60, 1, 4, 100, 100, 0, 0);
    // fully random traffic
    run_phase(600, 1, 5, 60, 60, 5, 0);
    reset_mid_stream();
    run_phase(300, 1, 4, 70, 50, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
